mac_stream: RTL

Parametrised, pipelined streaming multiply-accumulate unit for the arithmetic datapath. Consumes a valid/ready stream of operand pairs grouped into accumulation runs by `in_first`/`in_last` flags and emits one accumulated result per run. It adds signed/unsigned mode, saturation with a sticky overflow flag, a per-run term count, and full backpressure. It serves as the general MAC primitive for dot-product and filter engines.

---
 rtl/mac_stream.sv | 113 +++++++++++
 1 files changed

// File: rtl/mac_stream.sv
// Pipelined streaming multiply-accumulate: one result per first..last run,
// with signed/unsigned mode, optional saturation, sticky overflow and term count.
`timescale 1ns/1ps
module mac_stream #(
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);
  localparam int P_W = A_W + B_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // On overflow pick the clamp value in the direction of the overflow.
  function automatic logic [ACC_W-1:0] clamp_sum(input logic [ACC_W:0] s,
                                                 input logic o, input logic neg);
    if (!o || SATURATE == 0) return s[ACC_W-1:0];
    if (SIGNED == 0) return '1;
    return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  function automatic logic [CNT_W-1:0] next_cnt(input logic f, input logic [CNT_W-1:0] c);
    if (f) return CNT_W'(1);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic signed [P_W-1:0]   a_x, b_x, prod;
  logic signed [P_W-1:0]   p_p1;
  logic                    first_p1, last_p1, vld_p1;
  logic signed [ACC_W-1:0] acc_p2;
  logic                    ovf_p2;
  logic [CNT_W-1:0]        cnt_p2;

  logic signed [ACC_W-1:0] p_ext, base;
  logic [ACC_W:0]          sum;
  logic                    ovr;
  logic [ACC_W-1:0]        acc_nx;
  logic                    ovf_nx;
  logic [CNT_W-1:0]        cnt_nx;

  // A pending, unaccepted result freezes the whole pipeline.
  assign in_ready = !reset && !(out_valid && !out_ready);

  // Widening both operands first keeps one multiplier for both modes.
  assign a_x  = {{B_W{(SIGNED != 0) && a[A_W-1]}}, a};
  assign b_x  = {{A_W{(SIGNED != 0) && b[B_W-1]}}, b};
  assign prod = a_x * b_x;

  always_comb begin
    if (SIGNED != 0) p_ext = ACC_W'(p_p1);
    else             p_ext = ACC_W'($unsigned(p_p1));
    base = first_p1 ? '0 : acc_p2;
    sum  = {1'b0, base} + {1'b0, p_ext};
    if (SIGNED != 0)
      ovr = (base[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    else
      ovr = sum[ACC_W];
    acc_nx = clamp_sum(sum, ovr, base[ACC_W-1]);
    ovf_nx = (first_p1 ? 1'b0 : ovf_p2) | ovr;
    cnt_nx = next_cnt(first_p1, cnt_p2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_p1      <= '0;
      first_p1  <= 1'b0;
      last_p1   <= 1'b0;
      vld_p1    <= 1'b0;
      acc_p2    <= '0;
      ovf_p2    <= 1'b0;
      cnt_p2    <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else if (in_ready) begin
      // Stage 1: product and run flags
      vld_p1   <= in_valid;
      p_p1     <= prod;
      first_p1 <= in_first;
      last_p1  <= in_last;
      // Stage 2: accumulate and emit
      if (vld_p1) begin
        acc_p2 <= acc_nx;
        ovf_p2 <= ovf_nx;
        cnt_p2 <= cnt_nx;
      end
      if (vld_p1 && last_p1) begin
        out_valid <= 1'b1;
        out_acc   <= acc_nx;
        out_ovf   <= ovf_nx;
        out_cnt   <= cnt_nx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
